// File: rtl/pixgen_pkg.sv
// pixgen_pkg: shared widths, phase encoding and stream constants for the pixel generator output path.
package pixgen_pkg;
    localparam int PIX_W = 24;
    localparam int WORD_W = 32;
    localparam logic [3:0] TKEEP_ALL = 4'hF;
    typedef enum logic [1:0] {PH0, PH3, PH2, PH1} phase_t;
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words), with SOF/EOL framing.
module pixel_packer
    import pixgen_pkg::*;
#(
    parameter int PIX_PER_LINE = 640,
    parameter int LINES = 480
) (
    input  logic              out_stream_aclk,
    input  logic              periph_reset,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic [WORD_W-1:0] out_stream_tdata,
    output logic [3:0]        out_stream_tkeep,
    output logic              out_stream_tvalid,
    input  logic              out_stream_tready,
    output logic              out_stream_tuser,
    output logic              out_stream_tlast,
    output logic              align_err,
    output logic [9:0]        line_count
);
    if (PIX_PER_LINE % 4 != 0) begin : g_bad_line
        $error("pixel_packer: PIX_PER_LINE must be a multiple of 4");
    end

    phase_t phase, eff, nxt;
    logic [PIX_W-1:0] hold, hold_n;
    logic [WORD_W-1:0] word;
    logic sof_pending, accept, emit, misalign;

    assign in_ready = !out_stream_tvalid || out_stream_tready;
    assign accept = in_valid && in_ready;
    assign out_stream_tkeep = TKEEP_ALL;

    // A new SOF abandons whatever partial word was in flight and restarts at P0.
    always_comb begin
        eff = in_sof ? PH0 : phase;
        word = eff == PH0 ? {8'h00, in_data} :
               eff == PH3 ? {in_data[7:0], hold} :
               eff == PH2 ? {in_data[15:0], hold[15:0]} :
                            {in_data, hold[7:0]};
        hold_n = eff == PH0 ? in_data :
                 eff == PH3 ? {8'h00, in_data[23:8]} :
                              {16'h0000, in_data[23:16]};
        nxt = in_eol     ? PH0 :
              eff == PH0 ? PH3 :
              eff == PH3 ? PH2 :
              eff == PH2 ? PH1 : PH0;
        emit = in_eol || eff != PH0;
        misalign = (in_sof && phase != PH0) || (in_eol && eff != PH1);
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            phase <= PH0;
            hold <= '0;
            sof_pending <= 1'b0;
            line_count <= '0;
            align_err <= 1'b0;
            out_stream_tvalid <= 1'b0;
            out_stream_tdata <= '0;
            out_stream_tuser <= 1'b0;
            out_stream_tlast <= 1'b0;
        end else begin
            if (out_stream_tready) begin
                out_stream_tvalid <= 1'b0;
                out_stream_tuser <= 1'b0;
                out_stream_tlast <= 1'b0;
            end
            if (accept) begin
                phase <= nxt;
                hold <= hold_n;
                sof_pending <= (sof_pending || in_sof) && !emit;
                if (misalign)
                    align_err <= 1'b1;
                if (in_sof)
                    line_count <= '0;
                else if (in_eol && eff == PH1 && line_count != 10'(LINES - 1))
                    line_count <= line_count + 10'd1;
                if (emit) begin
                    out_stream_tvalid <= 1'b1;
                    out_stream_tdata <= word;
                    out_stream_tuser <= sof_pending || in_sof;
                    out_stream_tlast <= in_eol;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: randomized scoreboard bench for pixel_packer against a byte-stream reference model.
module tb_pixel_packer;
    localparam int LINES = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [23:0] in_data = '0;
    logic in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, tready = 1'b1;
    logic in_ready, tvalid, tuser, tlast, align_err;
    logic [31:0] tdata;
    logic [3:0] tkeep;
    logic [9:0] line_count;

    always #5 clk = ~clk;

    pixel_packer #(.PIX_PER_LINE(640), .LINES(LINES)) dut (
        .out_stream_aclk(clk), .periph_reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
        .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .out_stream_tuser(tuser), .out_stream_tlast(tlast),
        .align_err(align_err), .line_count(line_count)
    );

    int checks = 0, errors = 0;
    logic [33:0] exp_q[$];
    logic [31:0] got[$];
    logic [31:0] ref_line[$];
    logic [7:0] bq[$];
    bit sofp = 0, merr = 0;
    int mlc = 0, tlast_cnt = 0, mode = 0;
    bit gaps = 0;
    logic [32:0] lfsr = 33'd1246504138;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the input is just a byte stream cut into 4-byte words per line.
    task automatic model(input logic [23:0] p, input bit s, input bit e);
        logic [31:0] w;
        bit em;
        w = '0;
        em = 0;
        if (s) begin
            if (bq.size() != 0) merr = 1;
            bq.delete();
            sofp = 1;
            mlc = 0;
        end
        bq.push_back(p[7:0]);
        bq.push_back(p[15:8]);
        bq.push_back(p[23:16]);
        if (bq.size() >= 4) begin
            w = {bq[3], bq[2], bq[1], bq[0]};
            repeat (4) void'(bq.pop_front());
            em = 1;
        end
        if (e) begin
            if (!em) begin
                while (bq.size() < 4) bq.push_back(8'h00);
                w = {bq[3], bq[2], bq[1], bq[0]};
                bq.delete();
                em = 1;
                merr = 1;
            end else if (bq.size() != 0) begin
                merr = 1;
                bq.delete();
            end else if (mlc < LINES - 1) mlc++;
        end
        if (em) begin
            exp_q.push_back({w, sofp, e});
            sofp = 0;
        end
    endtask

    always @(negedge clk) begin
        chk("line_count", 32'(line_count), 32'(mlc));
        chk("align_err", 32'(align_err), 32'(merr));
        if (rst) begin
            bq.delete();
            exp_q.delete();
            sofp = 0;
            mlc = 0;
            merr = 0;
        end else if (in_valid && in_ready) model(in_data, in_sof, in_eol);
    end

    bit stall_prev = 0;
    logic [31:0] prev_data = '0;
    logic [33:0] e_w;
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("tvalid_held", 32'(tvalid), 32'd1);
            chk("tdata_stable", tdata, prev_data);
        end
        if (!rst && tvalid && !tready) chk("in_ready_stalled", 32'(in_ready), 32'd0);
        if (!rst && tvalid && tready) begin
            chk("tkeep", 32'(tkeep), 32'hF);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", tdata);
            end else begin
                e_w = exp_q.pop_front();
                chk("tdata", tdata, e_w[33:2]);
                chk("tuser", 32'(tuser), 32'(e_w[1]));
                chk("tlast", 32'(tlast), 32'(e_w[0]));
            end
            got.push_back(tdata);
            if (tlast) tlast_cnt++;
        end
        stall_prev = !rst && tvalid && !tready;
        prev_data = tdata;
    end

    always @(posedge clk) begin
        #1;
        lfsr = {lfsr[31:0], lfsr[32] ^ lfsr[19]};
        tready = mode == 0 ? 1'b1 : mode == 1 ? lfsr[0] : mode == 2 ? 1'b0 : 1'($urandom_range(1));
    end

    task automatic send(input logic [23:0] p, input bit s, input bit e);
        bit acc;
        int n;
        if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(2) + 1) begin
            @(posedge clk);
            #1;
        end
        in_data = p;
        in_sof = s;
        in_eol = e;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept for %h", p);
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [23:0] pix[640];
    logic [23:0] x;
    int k, diffs;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tvalid", 32'(tvalid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_tdata", tdata, 32'd0);
        @(posedge clk);
        #1;

        got.delete();
        send(24'h030201, 1, 0);
        send(24'h060504, 0, 0);
        send(24'h090807, 0, 0);
        send(24'h0C0B0A, 0, 0);
        drain();
        chk("dir_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("dir_w0", got[0], 32'h04030201);
            chk("dir_w1", got[1], 32'h08070605);
            chk("dir_w2", got[2], 32'h0C0B0A09);
        end

        for (int i = 0; i < 640; i++) pix[i] = 24'($urandom);
        got.delete();
        tlast_cnt = 0;
        for (int i = 0; i < 640; i++) send(pix[i], i == 0, i == 639);
        drain();
        chk("line_words", 32'(got.size()), 32'd480);
        chk("line_tlast", 32'(tlast_cnt), 32'd1);
        chk("line_count_1", 32'(line_count), 32'd1);
        ref_line = got;

        mode = 1;
        gaps = 1;
        got.delete();
        for (int i = 0; i < 640; i++) send(pix[i], i == 0, i == 639);
        drain();
        chk("prbs_words", 32'(got.size()), 32'd480);
        diffs = 0;
        for (int i = 0; i < got.size() && i < ref_line.size(); i++) if (got[i] !== ref_line[i]) diffs++;
        chk("prbs_same_seq", 32'(diffs), 32'd0);

        mode = 0;
        gaps = 0;
        for (int i = 0; i < 6; i++) send(24'($urandom), i == 0, i == 5);
        drain();
        chk("eol_mis_err", 32'(align_err), 32'd1);
        x = 24'($urandom);
        send(x, 0, 1);
        drain();
        chk("eol_p0_flush", got[got.size() - 1], {8'h00, x});
        for (int i = 0; i < 4; i++) send(24'($urandom), 0, 0);
        drain();

        send(24'($urandom), 0, 0);
        k = got.size();
        x = 24'($urandom);
        send(x, 1, 0);
        for (int i = 0; i < 3; i++) send(24'($urandom), 0, 0);
        drain();
        chk("sof_mid_count", 32'(got.size() - k), 32'd3);
        if (got.size() > k) chk("sof_mid_word", 32'(got[k][23:0]), 32'(x));

        mode = 2;
        send(24'($urandom), 1, 0);
        send(24'($urandom), 0, 0);
        @(negedge clk);
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        pulse_reset();
        @(negedge clk);
        chk("rst_mid_tvalid", 32'(tvalid), 32'd0);
        chk("rst_mid_lc", 32'(line_count), 32'd0);
        chk("rst_mid_err", 32'(align_err), 32'd0);
        @(posedge clk);
        #1 mode = 0;
        for (int i = 0; i < 8; i++) send(24'($urandom), i == 0, i == 7);
        drain();

        mode = 3;
        gaps = 1;
        for (int l = 0; l < 6; l++)
            for (int i = 0; i < 4; i++) send(24'($urandom), l == 0 && i == 0, i == 3);
        drain();
        chk("lc_saturate", 32'(line_count), 32'(LINES - 1));

        mode = 1;
        for (int i = 0; i < 1500; i++)
            send(24'($urandom), $urandom_range(49) == 0, $urandom_range(7) == 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
